// File: rtl/dmi_to_tl_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : dmi_to_tl_bridge
// Purpose : Turns one DMI request at a time into a single-beat TileLink-UL
//           Get/PutFullData and returns one DMI response per request.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module dmi_to_tl_bridge #(
    parameter int DMI_ADDR_BITS = 7,
    parameter int TL_ADDR_BITS  = 7,
    parameter int TIMEOUT       = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dmi_req_valid,
    output logic                     dmi_req_ready,
    input  logic [DMI_ADDR_BITS-1:0] dmi_req_addr,
    input  logic [31:0]              dmi_req_data,
    input  logic [1:0]               dmi_req_op,
    output logic                     dmi_resp_valid,
    input  logic                     dmi_resp_ready,
    output logic [31:0]              dmi_resp_data,
    output logic [1:0]               dmi_resp_resp,
    output logic                     tl_a_valid,
    input  logic                     tl_a_ready,
    output logic [2:0]               tl_a_opcode,
    output logic [TL_ADDR_BITS-1:0]  tl_a_address,
    output logic [31:0]              tl_a_data,
    input  logic                     tl_d_valid,
    output logic                     tl_d_ready,
    input  logic [2:0]               tl_d_opcode,
    input  logic                     tl_d_denied,
    input  logic [31:0]              tl_d_data,
    output logic                     busy
);

    localparam int c_AW    = TL_ADDR_BITS - 2;
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_SEND = 2'd1,
        D_WAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state_q;
    logic [c_AW-1:0]    addr_q;
    logic [31:0]        data_q;
    logic [1:0]         op_q;
    logic [31:0]        resp_data_q;
    logic [1:0]         resp_resp_q;
    logic [c_CNT_W-1:0] cnt_q;

    logic w_is_read;
    logic w_d_ok;

    assign w_is_read = (op_q == 2'd1);
    assign w_d_ok    = !tl_d_denied && (tl_d_opcode == (w_is_read ? 3'd1 : 3'd0));

    // Handshake signals decode the state register only; the slave loops a_ready to d_ready.
    assign dmi_req_ready  = (state_q == IDLE);
    assign tl_a_valid     = (state_q == A_SEND);
    assign tl_d_ready     = (state_q == A_SEND) || (state_q == D_WAIT);
    assign dmi_resp_valid = (state_q == RESP);
    assign busy           = (state_q != IDLE);

    assign tl_a_opcode  = w_is_read ? 3'd4 : 3'd0;
    assign tl_a_address = {addr_q, 2'b00};
    assign tl_a_data    = (op_q == 2'd2) ? data_q : 32'd0;

    assign dmi_resp_data = resp_data_q;
    assign dmi_resp_resp = resp_resp_q;

    generate
        if (DMI_ADDR_BITS > c_AW) begin : g_addr_trunc
            logic unused_addr_hi;
            assign unused_addr_hi = ^dmi_req_addr[DMI_ADDR_BITS-1:c_AW];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            op_q        <= '0;
            resp_data_q <= '0;
            resp_resp_q <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dmi_req_valid) begin
                        addr_q      <= dmi_req_addr[c_AW-1:0];
                        data_q      <= dmi_req_data;
                        op_q        <= dmi_req_op;
                        resp_data_q <= 32'd0;
                        resp_resp_q <= (dmi_req_op == 2'd3) ? 2'd2 : 2'd0;
                        if (dmi_req_op == 2'd1 || dmi_req_op == 2'd2) begin
                            state_q <= A_SEND;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                A_SEND: begin
                    // A D beat without an A fire is illegal and deliberately ignored.
                    if (tl_a_ready) begin
                        if (tl_d_valid) begin
                            resp_resp_q <= w_d_ok ? 2'd0 : 2'd2;
                            resp_data_q <= (w_d_ok && w_is_read) ? tl_d_data : 32'd0;
                            state_q     <= RESP;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= D_WAIT;
                        end
                    end
                end
                D_WAIT: begin
                    if (tl_d_valid) begin
                        resp_resp_q <= w_d_ok ? 2'd0 : 2'd2;
                        resp_data_q <= (w_d_ok && w_is_read) ? tl_d_data : 32'd0;
                        state_q     <= RESP;
                    end else if (TIMEOUT > 0 && cnt_q == c_CNT_LAST) begin
                        resp_resp_q <= 2'd2;
                        resp_data_q <= 32'd0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                RESP: begin
                    if (dmi_resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_no_orphan_d: assert property (@(posedge clock) disable iff (reset)
        !(state_q == A_SEND && tl_d_valid && !tl_a_ready));

endmodule
`default_nettype wire

// File: tb/tb_dmi_to_tl_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_dmi_to_tl_bridge
// Purpose : Directed plus random transactions against a transaction-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dmi_to_tl_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_op = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [1:0]  resp_resp;
    logic        a_valid;
    logic        a_ready = 1'b0;
    logic [2:0]  a_opcode;
    logic [6:0]  a_address;
    logic [31:0] a_data;
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic [2:0]  d_opcode = '0;
    logic        d_denied = 1'b0;
    logic [31:0] d_data = '0;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    dmi_to_tl_bridge #(
        .DMI_ADDR_BITS(7),
        .TL_ADDR_BITS (7),
        .TIMEOUT      (TMO)
    ) dut (
        .clock         (clk),
        .reset         (rst),
        .dmi_req_valid (req_valid),
        .dmi_req_ready (req_ready),
        .dmi_req_addr  (req_addr),
        .dmi_req_data  (req_data),
        .dmi_req_op    (req_op),
        .dmi_resp_valid(resp_valid),
        .dmi_resp_ready(resp_ready),
        .dmi_resp_data (resp_data),
        .dmi_resp_resp (resp_resp),
        .tl_a_valid    (a_valid),
        .tl_a_ready    (a_ready),
        .tl_a_opcode   (a_opcode),
        .tl_a_address  (a_address),
        .tl_a_data     (a_data),
        .tl_d_valid    (d_valid),
        .tl_d_ready    (d_ready),
        .tl_d_opcode   (d_opcode),
        .tl_d_denied   (d_denied),
        .tl_d_data     (d_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete DMI transaction; the slave waits a_stall cycles before a_ready,
    // answers d_lat cycles after the A fire (0 = same cycle), and the DTM stalls the response.
    task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                          input int a_stall, input int d_lat, input logic [2:0] dop,
                          input logic den, input logic [31:0] rdata, input int resp_stall);
        logic        is_tl;
        logic        timed_out;
        logic        ok;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        logic [6:0]  exp_addr;
        is_tl     = (op == 2'd1) || (op == 2'd2);
        timed_out = is_tl && (d_lat > TMO);
        exp_addr  = 7'((addr * 4) % 128);

        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_data = wdata; req_op = op;
        step();
        req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_op = 2'($urandom);

        if (is_tl) begin
            for (int k = 0; k <= a_stall; k++) begin
                chk("a_valid", {31'd0, a_valid}, 32'd1);
                chk("a_opcode", {29'd0, a_opcode}, (op == 2'd1) ? 32'd4 : 32'd0);
                chk("a_address", {25'd0, a_address}, {25'd0, exp_addr});
                chk("a_data", a_data, (op == 2'd2) ? wdata : 32'd0);
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                chk("d_ready_asend", {31'd0, d_ready}, 32'd1);
                a_ready = (k == a_stall);
                if (k == a_stall && d_lat == 0) begin
                    d_valid = 1'b1; d_opcode = dop; d_denied = den; d_data = rdata;
                end
                step();
                a_ready = 1'b0; d_valid = 1'b0;
            end
            if (d_lat > 0) begin
                for (int c = 1; c <= TMO; c++) begin
                    chk("dwait_d_ready", {31'd0, d_ready}, 32'd1);
                    chk("dwait_a_valid", {31'd0, a_valid}, 32'd0);
                    chk("dwait_resp_valid", {31'd0, resp_valid}, 32'd0);
                    if (c == d_lat) begin
                        d_valid = 1'b1; d_opcode = dop; d_denied = den; d_data = rdata;
                        step();
                        d_valid = 1'b0;
                        break;
                    end
                    step();
                end
            end
        end

        ok = !den && (dop == ((op == 2'd1) ? 3'd1 : 3'd0));
        if (op == 2'd0) begin
            exp_resp = 2'd0; exp_data = 32'd0;
        end else if (op == 2'd3 || timed_out || !ok) begin
            exp_resp = 2'd2; exp_data = 32'd0;
        end else begin
            exp_resp = 2'd0; exp_data = (op == 2'd1) ? rdata : 32'd0;
        end

        for (int s = 0; s <= resp_stall; s++) begin
            chk("resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("resp_data", resp_data, exp_data);
            chk("resp_resp", {30'd0, resp_resp}, {30'd0, exp_resp});
            chk("resp_no_a", {31'd0, a_valid}, 32'd0);
            chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
            resp_ready = (s == resp_stall);
            step();
            resp_ready = 1'b0;
        end
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [2:0]  dop;
        int          dl;

        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_resp", {30'd0, resp_resp}, 32'd0);
        rst = 1'b0;
        step();

        do_txn(2'd2, 7'h10, 32'h8000_0001, 0, 0, 3'd0, 1'b0, 32'hDEAD_BEEF, 0);
        do_txn(2'd1, 7'h11, 32'h0, 0, 2, 3'd1, 1'b0, 32'h0011_8380, 0);
        do_txn(2'd0, 7'h05, 32'h1234_5678, 0, 0, 3'd0, 1'b0, 32'h0, 0);
        do_txn(2'd3, 7'h06, 32'h1234_5678, 0, 0, 3'd0, 1'b0, 32'h0, 1);
        do_txn(2'd2, 7'h7F, 32'hA5A5_5A5A, 5, 1, 3'd0, 1'b0, 32'h0, 4);
        do_txn(2'd1, 7'h22, 32'h0, 0, 100, 3'd1, 1'b0, 32'hFFFF_FFFF, 0);
        do_txn(2'd1, 7'h23, 32'h0, 1, TMO, 3'd1, 1'b0, 32'hCAFE_F00D, 0);
        do_txn(2'd1, 7'h24, 32'h0, 0, 1, 3'd1, 1'b1, 32'h1111_2222, 0);
        do_txn(2'd1, 7'h25, 32'h0, 0, 0, 3'd0, 1'b0, 32'h3333_4444, 0);

        // Reset while waiting for D.
        req_valid = 1'b1; req_addr = 7'h30; req_op = 2'd1;
        step();
        req_valid = 1'b0;
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        step();
        chk("pre_rst_d_ready", {31'd0, d_ready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("arst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("post_rst_a_valid", {31'd0, a_valid}, 32'd0);
        end
        do_txn(2'd1, 7'h31, 32'h0, 0, 0, 3'd1, 1'b0, 32'h0BAD_CAFE, 0);

        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom_range(0, 3));
            dl  = ($urandom_range(0, 9) == 9) ? 20 : int'($urandom_range(0, 3));
            dop = ($urandom_range(0, 7) == 0) ? 3'($urandom) : ((op == 2'd1) ? 3'd1 : 3'd0);
            do_txn(op, 7'($urandom), $urandom, int'($urandom_range(0, 3)), dl, dop,
                   ($urandom_range(0, 7) == 0), $urandom, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmi_to_tl_bridge.md
Name: dmi_to_tl_bridge

Overview:
Converts Debug Module Interface (DMI) requests from the debug transport (JTAG DTM side) into single-beat TileLink-UL transactions on the debug module's DMI TL port. It returns one DMI response per request. The block sits directly upstream of the debug module outer block and drives its dmi A channel and sinks its D channel. There is one outstanding transaction at a time; request fields are fully registered and the response is held until it is accepted.

Parameters:
DMI_ADDR_BITS, 7, DMI word address width
TL_ADDR_BITS, 7, TL byte address width driven on a_address
TIMEOUT, 0, D-channel wait limit in cycles; 0 disables timeout

Ports:
clock  in  1  clock
reset  in  1  reset, asynchronous, active-high
dmi_req_valid  in  1  DMI request valid
dmi_req_ready  out  1  DMI request ready
dmi_req_addr  in  DMI_ADDR_BITS  DMI register word address
dmi_req_data  in  32  write data
dmi_req_op  in  2  0 = NOP, 1 = read, 2 = write, 3 = reserved
dmi_resp_valid  out  1  response valid
dmi_resp_ready  in  1  response ready
dmi_resp_data  out  32  read data (0 for NOP, write or fail)
dmi_resp_resp  out  2  0 = success, 2 = failed
tl_a_valid  out  1  A valid
tl_a_ready  in  1  A ready
tl_a_opcode  out  3  4 = Get, 0 = PutFullData
tl_a_address  out  TL_ADDR_BITS  byte address
tl_a_data  out  32  PutFullData payload
tl_d_valid  in  1  D valid
tl_d_ready  out  1  D ready
tl_d_opcode  in  3  1 = AccessAckData, 0 = AccessAck
tl_d_denied  in  1  denied flag
tl_d_data  in  32  D data
busy  out  1  state != IDLE

Behaviour:
- Reset values: state = IDLE, every valid output = 0, all held registers = 0, busy = 0.
- Readiness is derived from state only. There is no combinational path from any TL input to tl_d_ready or tl_a_valid, because the downstream block ties a_ready to d_ready combinationally.
- dmi_req_ready = (state == IDLE). tl_a_valid = (state == A_SEND). tl_d_ready = (state == A_SEND or state == D_WAIT). dmi_resp_valid = (state == RESP).
- IDLE state:
  - On dmi_req_valid, register addr, data and op.
  - Op 1 or 2 -> A_SEND.
  - Op 0 -> RESP with data = 0, resp = 0, and no TL traffic.
  - Op 3 -> RESP with data = 0, resp = 2, and no TL traffic.
- A_SEND state:
  - Drive tl_a_opcode = 4 for a read, 0 for a write.
  - tl_a_address = {req_addr[TL_ADDR_BITS-3:0], 2'b00}.
  - tl_a_data = req_data for a write, 0 for a read.
  - On A fire (a_valid & a_ready):
    - If tl_d_valid is high in the same cycle, capture D and go to RESP. This is the zero-latency slave case.
    - Otherwise go to D_WAIT and clear the timeout counter.
  - tl_d_valid without an A fire in this state is a protocol violation. It is ignored (no capture, no state change) and flagged by a simulation assertion.
  - A fields stay stable while stalled.
- D_WAIT state:
  - On tl_d_valid, capture D and go to RESP.
  - If TIMEOUT > 0, the counter (width clog2(TIMEOUT+1)) increments each cycle without D. When it reaches TIMEOUT-1 without D, go to RESP with resp = 2 and data = 0.
  - A D beat arriving later is dropped silently: tl_d_ready is 0 outside A_SEND and D_WAIT.
- D capture rules:
  - resp = 2 if tl_d_denied is set, or if the opcode does not match the request: read expects 1, write expects 0.
  - Otherwise resp = 0.
  - resp_data = tl_d_data for a successful read, else 0.
- RESP state:
  - Hold dmi_resp_data and dmi_resp_resp stable until dmi_resp_ready, then go to IDLE.
  - The next request cannot be accepted in the same cycle. Minimum spacing is two cycles for a NOP and three cycles for a zero-latency TL round trip.
- Reset asserted mid-transaction returns the block to IDLE immediately, with all valids deasserted asynchronously. Any in-flight TL response is the slave's problem; after reset the bridge issues no stray A.

Test Plan:
- Write: req op = 2, addr = 0x10, data = 0x80000001 with the slave answering AccessAck in the same cycle.
  - Required: a_opcode = 0, a_address = 0x40 truncated to 7 bits = 0x40, a_data = 0x80000001.
  - Required: resp_valid one cycle after the A fire, resp = 0, data = 0.
- Read: req op = 1, addr = 0x11 with the slave returning AccessAckData, data = 0x00118380.
  - Required: a_opcode = 4, resp_data = 0x00118380, resp = 0.
- NOP and reserved ops:
  - op = 0 -> no A valid ever; the next cycle gives resp_valid with resp = 0, data = 0.
  - op = 3 -> no A valid; resp = 2.
- Backpressure: hold tl_a_ready = 0 for 5 cycles, then hold dmi_resp_ready = 0 for 4 cycles.
  - Required: A fields stable throughout, req_ready = 0 throughout, response data stable until accepted, then req_ready = 1 the next cycle.
- Timeout and denied: TIMEOUT = 8, the slave never returns D.
  - Required: resp = 2 after exactly 8 D_WAIT cycles.
  - Separately, d_denied = 1 on a read -> resp = 2, data = 0.
- Reset in D_WAIT: assert reset for 1 cycle.
  - Required: busy = 0 and tl_d_ready = 0 asynchronously, no response emitted, and the next request completes normally.
